conv_encoder: RTL and testbench

Framed rate-1/2, constraint-length-9 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder. Its shift-register convention matches the decoder's traceback state update (newest bit enters at the state LSB, decoded bit is the state MSB), so decoded output reproduces the encoder input exactly. Each frame is terminated with 8 zero tail bits, which returns the trellis to state 0, the decoder's traceback initial state. Data bits come in over a valid/ready stream and 2-bit code symbols go out over a valid/ready stream with frame markers.

---
 rtl/conv_encoder_pkg.sv | 22 ++
 rtl/conv_enc_core.sv | 22 ++
 rtl/conv_encoder.sv | 147 ++++++++++++++
 tb/tb_conv_encoder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_encoder_pkg.sv
// Shared constants and types for the framed rate-1/2, K=9 convolutional encoder.
package conv_encoder_pkg;

    localparam int unsigned WD_STATE  = 8;
    localparam int unsigned WD_SYMBOL = 2;
    localparam int unsigned TAIL_LEN  = WD_STATE;

    localparam logic [WD_STATE:0] G0_DEFAULT = 9'o561;
    localparam logic [WD_STATE:0] G1_DEFAULT = 9'o753;

    typedef enum logic [1:0] {
        CE_IDLE = 2'd0,
        CE_DATA = 2'd1,
        CE_TAIL = 2'd2
    } ce_state_e;

    // Symbols produced by a terminated frame carrying n_bits information bits.
    function automatic int unsigned frame_symbols(input int unsigned n_bits);
        return n_bits + TAIL_LEN;
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational encoder step: window {S, d} -> code symbol {c0, c1} and next state.
module conv_enc_core #(
    parameter int unsigned       WD_STATE = conv_encoder_pkg::WD_STATE,
    parameter logic [WD_STATE:0] G0       = conv_encoder_pkg::G0_DEFAULT,
    parameter logic [WD_STATE:0] G1       = conv_encoder_pkg::G1_DEFAULT
) (
    input  logic [WD_STATE-1:0]                    state_i,
    input  logic                                   bit_i,
    output logic [conv_encoder_pkg::WD_SYMBOL-1:0] symbol_o,
    output logic [WD_STATE-1:0]                    state_next_o
);

    logic [WD_STATE:0] window;

    // Newest bit sits at the window LSB so the decoder's traceback sees it at state LSB.
    always_comb begin
        window       = {state_i, bit_i};
        symbol_o     = {^(window & G0), ^(window & G1)};
        state_next_o = window[WD_STATE-1:0];
    end

endmodule

// File: rtl/conv_encoder.sv
// Framed convolutional encoder: valid/ready bit input, 2-bit symbol output with
// frame markers, each frame flushed back to state 0 by WD_STATE zero tail bits.
module conv_encoder #(
    parameter int unsigned       WD_STATE = conv_encoder_pkg::WD_STATE,
    parameter logic [WD_STATE:0] G0       = conv_encoder_pkg::G0_DEFAULT,
    parameter logic [WD_STATE:0] G1       = conv_encoder_pkg::G1_DEFAULT,
    parameter int unsigned       WD_COUNT = 16
) (
    input  logic                                   Clock,
    input  logic                                   Reset,
    input  logic                                   InValid,
    output logic                                   InReady,
    input  logic                                   InData,
    input  logic                                   InLast,
    output logic                                   OutValid,
    input  logic                                   OutReady,
    output logic [conv_encoder_pkg::WD_SYMBOL-1:0] OutSymbol,
    output logic                                   OutFirst,
    output logic                                   OutLast,
    output logic [WD_COUNT-1:0]                    SymCount
);

    import conv_encoder_pkg::*;

    localparam int unsigned        WD_TAIL   = (WD_STATE > 1) ? $clog2(WD_STATE) : 1;
    localparam logic [WD_TAIL-1:0] TAIL_LAST = WD_TAIL'(WD_STATE - 1);

    ce_state_e            state_q, state_d;
    logic [WD_STATE-1:0]  sreg_q, sreg_d;
    logic [WD_TAIL-1:0]   tail_q, tail_d;
    logic                 out_valid_q, out_valid_d;
    logic [WD_SYMBOL-1:0] out_sym_q, out_sym_d;
    logic                 out_first_q, out_first_d;
    logic                 out_last_q, out_last_d;
    logic [WD_COUNT-1:0]  sym_cnt_q, sym_cnt_d;

    logic                 out_free;
    logic                 in_ready;
    logic                 in_fire;
    logic                 tail_fire;
    logic                 core_bit;
    logic [WD_SYMBOL-1:0] core_sym;
    logic [WD_STATE-1:0]  core_next;

    // Output register can take a new symbol if empty or drained this same cycle.
    assign out_free  = !out_valid_q || OutReady;
    assign in_ready  = !Reset && out_free && (state_q != CE_TAIL);
    assign in_fire   = InValid && in_ready;
    assign tail_fire = out_free && (state_q == CE_TAIL);
    assign core_bit  = (state_q == CE_TAIL) ? 1'b0 : InData;

    conv_enc_core #(
        .WD_STATE (WD_STATE),
        .G0       (G0),
        .G1       (G1)
    ) u_core (
        .state_i      (sreg_q),
        .bit_i        (core_bit),
        .symbol_o     (core_sym),
        .state_next_o (core_next)
    );

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        tail_d      = tail_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        sym_cnt_d   = sym_cnt_q;

        if (in_fire || tail_fire) begin
            out_valid_d = 1'b1;
            out_sym_d   = core_sym;
            out_first_d = (state_q == CE_IDLE);
            out_last_d  = tail_fire && (tail_q == TAIL_LAST);
            sreg_d      = core_next;
            if (state_q == CE_IDLE) begin
                sym_cnt_d = WD_COUNT'(1);
            end else if (sym_cnt_q != '1) begin
                sym_cnt_d = sym_cnt_q + WD_COUNT'(1);
            end
        end else if (out_free) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            CE_IDLE: begin
                if (in_fire) begin
                    state_d = InLast ? CE_TAIL : CE_DATA;
                    tail_d  = '0;
                end
            end
            CE_DATA: begin
                if (in_fire && InLast) begin
                    state_d = CE_TAIL;
                    tail_d  = '0;
                end
            end
            CE_TAIL: begin
                if (tail_fire) begin
                    if (tail_q == TAIL_LAST) begin
                        state_d = CE_IDLE;
                        tail_d  = '0;
                    end else begin
                        tail_d = tail_q + WD_TAIL'(1);
                    end
                end
            end
            default: begin
                state_d = CE_IDLE;
                tail_d  = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= CE_IDLE;
            sreg_q      <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            sym_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            sym_cnt_q   <= sym_cnt_d;
        end
    end

    assign InReady   = in_ready;
    assign OutValid  = out_valid_q;
    assign OutSymbol = out_sym_q;
    assign OutFirst  = out_first_q;
    assign OutLast   = out_last_q;
    assign SymCount  = sym_cnt_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder against a convolution-sum reference model.
module tb_conv_encoder;

    localparam logic [8:0] G0   = 9'o561;
    localparam logic [8:0] G1   = 9'o753;
    localparam int         TAIL = 8;

    typedef struct packed {
        logic [1:0]  sym;
        logic        first;
        logic        last;
        logic [15:0] cnt;
    } sym_t;

    logic        Clock    = 1'b0;
    logic        Reset    = 1'b1;
    logic        InValid  = 1'b0;
    logic        InData   = 1'b0;
    logic        InLast   = 1'b0;
    logic        OutReady = 1'b1;
    logic        InReady;
    logic        OutValid;
    logic [1:0]  OutSymbol;
    logic        OutFirst;
    logic        OutLast;
    logic [15:0] SymCount;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   tx_bits[$];
    bit   tx_last[$];
    sym_t rx[$];
    sym_t exp_q[$];
    int   stall_err;
    int   first_cyc;
    int   last_cyc;
    int   drv_idx;
    bit   drv_timeout;

    conv_encoder #(
        .WD_COUNT (16)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .InValid   (InValid),
        .InReady   (InReady),
        .InData    (InData),
        .InLast    (InLast),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutSymbol (OutSymbol),
        .OutFirst  (OutFirst),
        .OutLast   (OutLast),
        .SymCount  (SymCount)
    );

    always #5 Clock = ~Clock;

    // Code bit k of a frame is the GF(2) convolution of the zero-padded input with g.
    function automatic logic conv_bit(input bit h[$], input int k, input logic [8:0] g);
        logic r = 1'b0;
        for (int j = 0; j <= 8; j++)
            if (g[j] && (k - j) >= 0) r ^= h[k - j];
        return r;
    endfunction

    function automatic void build_expected();
        bit   hist[$];
        sym_t e;
        exp_q.delete();
        foreach (tx_bits[i]) begin
            hist.push_back(tx_bits[i]);
            if (tx_last[i]) begin
                repeat (TAIL) hist.push_back(1'b0);
                foreach (hist[k]) begin
                    e.sym   = {conv_bit(hist, k, G0), conv_bit(hist, k, G1)};
                    e.first = (k == 0);
                    e.last  = (k == hist.size() - 1);
                    e.cnt   = 16'(k + 1);
                    exp_q.push_back(e);
                end
                hist.delete();
            end
        end
    endfunction

    function automatic void add_random_frame(input int n);
        for (int i = 0; i < n; i++) begin
            tx_bits.push_back(1'($urandom));
            tx_last.push_back(i == n - 1);
        end
    endfunction

    // Stimulus driver: offers tx_bits, collects consumed symbols into rx.
    task automatic drive(input int rdy_pct, input int vld_pct, input int abort_after, input int max_cyc);
        int         nlast = 0;
        int         frames = 0;
        int         cyc = 0;
        logic       prev_stall = 1'b0;
        logic [3:0] prev_out = '0;
        sym_t       s;
        foreach (tx_last[i]) if (tx_last[i]) frames++;
        rx.delete();
        stall_err = 0; drv_timeout = 0; first_cyc = -1; last_cyc = -1; drv_idx = 0;
        forever begin
            if (cyc >= max_cyc) begin drv_timeout = 1; break; end
            OutReady = (int'($urandom_range(99)) < rdy_pct);
            if (drv_idx < tx_bits.size() && int'($urandom_range(99)) < vld_pct) begin
                InValid = 1'b1; InData = tx_bits[drv_idx]; InLast = tx_last[drv_idx];
            end else begin
                InValid = 1'b0; InData = 1'($urandom); InLast = 1'($urandom);
            end
            @(negedge Clock);
            if (prev_stall && ({OutValid, OutSymbol, OutFirst, OutLast} !== {1'b1, prev_out}))
                stall_err++;
            if (InValid && InReady) drv_idx++;
            if (OutValid && OutReady) begin
                s.sym = OutSymbol; s.first = OutFirst; s.last = OutLast; s.cnt = SymCount;
                rx.push_back(s);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (OutLast) nlast++;
            end
            prev_stall = OutValid && !OutReady;
            prev_out   = {OutSymbol, OutFirst, OutLast};
            @(posedge Clock); #1;
            cyc++;
            if (nlast == frames || (abort_after > 0 && rx.size() == abort_after)) break;
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; InValid = 1'b1; InData = 1'b1; InLast = 1'b0; OutReady = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        n_cmp++;
        if ({OutValid, OutSymbol, OutFirst, OutLast} !== 5'b0 || SymCount !== 16'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b sym=%b f=%b l=%b cnt=%0d, expected all zero",
                     OutValid, OutSymbol, OutFirst, OutLast, SymCount);
        end
        n_cmp++;
        if (InReady !== 1'b0) begin
            n_err++; $display("FAIL reset_inready: got %b, expected 0", InReady);
        end
        @(posedge Clock); #1;
        Reset = 1'b0; InValid = 1'b0; #1;
        n_cmp++;
        if (InReady !== 1'b1) begin
            n_err++; $display("FAIL post_reset_inready: got %b, expected 1", InReady);
        end
    endtask

    task automatic test_impulse(input string tag);
        logic [1:0] golden [9] = '{2'b11, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11};
        tx_bits.delete(); tx_last.delete();
        tx_bits.push_back(1'b1); tx_last.push_back(1'b1);
        build_expected();
        drive(100, 100, 0, 100);
        n_cmp++;
        if (drv_timeout || rx.size() != 9) begin
            n_err++; $display("FAIL %s_len: got %0d symbols (timeout=%0b), expected 9", tag, rx.size(), drv_timeout);
        end
        for (int i = 0; i < 9 && i < rx.size(); i++) begin
            n_cmp++;
            if (rx[i].sym !== golden[i] || rx[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s_sym[%0d]: got sym=%b f=%b l=%b cnt=%0d, expected sym=%b f=%b l=%b cnt=%0d",
                         tag, i, rx[i].sym, rx[i].first, rx[i].last, rx[i].cnt,
                         golden[i], exp_q[i].first, exp_q[i].last, exp_q[i].cnt);
            end
        end
        repeat (3) @(posedge Clock);
        #1;
        n_cmp++;
        if (SymCount !== 16'd9 || OutValid !== 1'b0) begin
            n_err++; $display("FAIL %s_hold: got cnt=%0d valid=%b, expected cnt=9 valid=0", tag, SymCount, OutValid);
        end
    endtask

    task automatic test_all_zero();
        tx_bits.delete(); tx_last.delete();
        for (int i = 0; i < 20; i++) begin tx_bits.push_back(1'b0); tx_last.push_back(i == 19); end
        build_expected();
        drive(100, 100, 0, 200);
        n_cmp++;
        if (drv_timeout || rx.size() != 28) begin
            n_err++; $display("FAIL zero_len: got %0d symbols (timeout=%0b), expected 28", rx.size(), drv_timeout);
        end
        foreach (rx[i]) begin
            n_cmp++;
            if (i >= 28 || rx[i].sym !== 2'b00 || rx[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL zero_sym[%0d]: got sym=%b f=%b l=%b cnt=%0d, expected sym=00 last=%0b cnt=%0d",
                         i, rx[i].sym, rx[i].first, rx[i].last, rx[i].cnt, i == 27, i + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        tx_bits.delete(); tx_last.delete();
        add_random_frame(5);
        for (int i = 0; i < 5; i++) begin tx_bits.push_back(tx_bits[i]); tx_last.push_back(i == 4); end
        build_expected();
        drive(100, 100, 0, 200);
        n_cmp++;
        if (drv_timeout || rx.size() != 26) begin
            n_err++; $display("FAIL b2b_len: got %0d symbols (timeout=%0b), expected 26", rx.size(), drv_timeout);
        end
        n_cmp++;
        if (last_cyc - first_cyc != 25) begin
            n_err++; $display("FAIL b2b_gapless: got span %0d cycles, expected 25", last_cyc - first_cyc);
        end
        foreach (rx[i]) begin
            n_cmp++;
            if (i >= 26 || rx[i] !== exp_q[i] || (i >= 13 && rx[i] !== rx[i - 13])) begin
                n_err++;
                $display("FAIL b2b_sym[%0d]: got %h, expected %h", i, rx[i], (i < 26) ? exp_q[i] : '0);
            end
        end
    endtask

    task automatic test_backpressure();
        tx_bits.delete(); tx_last.delete();
        add_random_frame(64);
        build_expected();
        drive(50, 70, 0, 3000);
        n_cmp++;
        if (drv_timeout || rx.size() != 72 || drv_idx != 64) begin
            n_err++;
            $display("FAIL bp_len: got %0d symbols, %0d bits taken (timeout=%0b), expected 72 and 64",
                     rx.size(), drv_idx, drv_timeout);
        end
        n_cmp++;
        if (stall_err != 0) begin
            n_err++; $display("FAIL bp_stable: got %0d stall changes, expected 0", stall_err);
        end
        foreach (rx[i]) begin
            n_cmp++;
            if (i >= 72 || rx[i] !== exp_q[i]) begin
                n_err++; $display("FAIL bp_sym[%0d]: got %h, expected %h", i, rx[i], (i < 72) ? exp_q[i] : '0);
            end
        end
    endtask

    task automatic test_reset_mid_tail();
        tx_bits.delete(); tx_last.delete();
        add_random_frame(6);
        build_expected();
        drive(100, 100, 9, 200);
        n_cmp++;
        if (rx.size() != 9) begin
            n_err++; $display("FAIL midtail_pre: got %0d symbols before reset, expected 9", rx.size());
        end
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        n_cmp++;
        if (OutValid !== 1'b0 || SymCount !== 16'd0) begin
            n_err++; $display("FAIL midtail_reset: got valid=%b cnt=%0d, expected valid=0 cnt=0", OutValid, SymCount);
        end
        @(posedge Clock); #1;
        Reset = 1'b0; #1;
        n_cmp++;
        if (InReady !== 1'b1 || OutValid !== 1'b0) begin
            n_err++; $display("FAIL midtail_idle: got ready=%b valid=%b, expected ready=1 valid=0", InReady, OutValid);
        end
        test_impulse("midtail_impulse");
    endtask

    task automatic test_loopback();
        bit dec[$];
        int bad = 0;
        tx_bits.delete(); tx_last.delete();
        add_random_frame(200);
        build_expected();
        drive(75, 80, 0, 5000);
        n_cmp++;
        if (drv_timeout || rx.size() != 208) begin
            n_err++; $display("FAIL loop_len: got %0d symbols (timeout=%0b), expected 208", rx.size(), drv_timeout);
        end
        foreach (rx[i]) begin
            n_cmp++;
            if (i >= 208 || rx[i] !== exp_q[i]) begin
                n_err++; $display("FAIL loop_sym[%0d]: got %h, expected %h", i, rx[i], (i < 208) ? exp_q[i] : '0);
            end
        end
        // Noiseless inverse of the c0 stream: G0 taps the newest bit, so it can be solved for.
        foreach (rx[k]) begin
            logic b = rx[k].sym[1];
            for (int j = 1; j <= 8; j++)
                if (G0[j] && (k - j) >= 0) b ^= dec[k - j];
            dec.push_back(b);
        end
        foreach (dec[k]) if (dec[k] != ((k < 200) ? tx_bits[k] : 1'b0)) bad++;
        n_cmp++;
        if (bad != 0 || !rx[0].first || (rx.size() > 0 && !rx[rx.size() - 1].last)) begin
            n_err++; $display("FAIL loop_decode: got %0d decoded bit errors, expected 0", bad);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_impulse("impulse");
        test_all_zero();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_tail();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
